// File: rtl/i2s_source_tx.sv
// I2S (Philips) master transmitter: stereo 24-bit frame FIFO feeding a bclk/lrclk/sdata serializer.
// Define I2S_TX_UNDERRUN_REPEAT_EN to repeat the last popped frame on underrun instead of sending zeros.
module i2s_source_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int BCLK_DIV   = 4,
  parameter int SLOT_BITS  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic [23:0]                   l_data_in,
  input  logic [23:0]                   r_data_in,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic                          frame_stb,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic                    stb_q, stb_d;
  logic                    und_q, und_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;

  logic [47:0]             mem_q [FIFO_DEPTH];
  logic [47:0]             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;

  logic                    full, empty, push, pop, load;
  logic [47:0]             src;
  logic [SLOT_BITS-1:0]    l_slot, r_slot;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [47:0]             last_q, last_d;
`endif

  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  assign din_ready  = !full;
  assign push       = din_valid && !full;
  assign pop        = load && !empty;

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign frame_stb  = stb_q;
  assign underrun   = und_q;
  assign fifo_level = level_q;

  // Frame source: head of FIFO, or the underrun fill pattern when empty.
  always_comb begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    src = empty ? last_q : mem_q[rd_ptr_q];
`else
    src = empty ? '0 : mem_q[rd_ptr_q];
`endif
    // One-bit I2S delay: MSB sits one slot position after the lrclk edge.
    l_slot = '0;
    r_slot = '0;
    l_slot[SLOT_BITS-2 -: 24] = src[47:24];
    r_slot[SLOT_BITS-2 -: 24] = src[23:0];
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    bclk_d  = bclk_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    shift_d = shift_q;
    stb_d   = 1'b0;
    und_d   = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        div_d   = '0;
        bit_d   = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        if (enable) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (div_q == DIV_W'(BCLK_DIV - 1)) begin
          div_d  = '0;
          bclk_d = !bclk_q;
          if (bclk_q) begin
            // Falling bclk edge: advance bit position, data and word select change here.
            if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
              bit_d = '0;
              if (enable) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
              end
            end else begin
              bit_d   = bit_q + 1'b1;
              shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
              sdata_d = shift_q[FRAME_BITS-2];
              lrclk_d = (bit_d >= BIT_W'(SLOT_BITS));
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d = {l_slot, r_slot};
      sdata_d = l_slot[SLOT_BITS-1];
      lrclk_d = 1'b0;
      bit_d   = '0;
      stb_d   = 1'b1;
      und_d   = empty;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {l_data_in, r_data_in};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  always_comb begin
    last_d = pop ? mem_q[rd_ptr_q] : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= '0;
    else       last_q <= last_d;
  end
`endif

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      stb_q    <= 1'b0;
      und_q    <= 1'b0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      stb_q    <= stb_d;
      und_q    <= und_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: tb/tb_i2s_source_tx.sv
// Directed bench for i2s_source_tx: bclk-rising receiver capture against hand-built frame images.
module tb_i2s_source_tx;

  localparam int FD = 4;
  localparam int BD = 2;
  localparam int SB = 32;

  logic        clk = 1'b0;
  logic        reset, enable, din_valid, din_ready;
  logic [23:0] l_data_in, r_data_in;
  logic        bclk, lrclk, sdata, frame_stb, underrun;
  logic [2:0]  fifo_level;

  i2s_source_tx #(.FIFO_DEPTH(FD), .BCLK_DIV(BD), .SLOT_BITS(SB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .din_valid(din_valid),
    .din_ready(din_ready), .l_data_in(l_data_in), .r_data_in(r_data_in),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .frame_stb(frame_stb),
    .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [23:0] fl [4] = '{24'h800001, 24'h123456, 24'hABCDEF, 24'h000001};
  logic [23:0] fr [4] = '{24'h7FFFFE, 24'hFEDCBA, 24'h654321, 24'hFFFFFF};
  localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

  logic [63:0] d, lr;
  int          first, nstb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; din_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic write_frame(input logic [23:0] l, input logic [23:0] r);
    din_valid = 1'b1; l_data_in = l; r_data_in = r;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic wait_stb(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (!frame_stb && n < 2000);
    chk({tag, "_stb_seen"}, frame_stb, 1'b1);
  endtask

  // Starts at the negedge where frame_stb is seen; records sdata/lrclk on each bclk rise.
  task automatic capture(input int nrise, input int drop_at, output logic [63:0] bits,
                         output logic [63:0] lrs, output int first_cyc);
    int   rises, cyc;
    logic prev;
    rises = 0; cyc = 0; prev = bclk;
    bits = '0; lrs = '0; first_cyc = -1;
    while (rises < nrise && cyc < 4000) begin
      tick(); cyc++;
      if (bclk && !prev) begin
        bits = {bits[62:0], sdata};
        lrs  = {lrs[62:0], lrclk};
        if (rises == 0) first_cyc = cyc;
        if (rises == drop_at) enable = 1'b0;
        rises++;
      end
      prev = bclk;
    end
    chk("capture_rises", rises, nrise);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; din_valid = 1'b0; l_data_in = '0; r_data_in = '0;
    repeat (3) tick();
    chk("rst_bclk", bclk, 1'b0);
    chk("rst_lrclk", lrclk, 1'b0);
    chk("rst_sdata", sdata, 1'b0);
    chk("rst_stb", frame_stb, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_ready", din_ready, 1'b1);
    reset = 1'b0;
    tick();
    chk("idle_bclk", bclk, 1'b0);

    // Empty FIFO start: underrun with the first load, zero frame
    enable = 1'b1;
    wait_stb("t1");
    chk("t1_underrun", underrun, 1'b1);
    chk("t1_bclk_low", bclk, 1'b0);
    capture(64, -1, d, lr, first);
    chk("t1_first_rise", first, 2);
    chk("t1_data", d, 64'h0);
    chk("t1_lrclk", lr, LR_EXP);

    // Single buffered frame
    do_reset();
    write_frame(24'hA5C3F1, 24'h5A3C0F);
    chk("t2_level", fifo_level, 3'd1);
    enable = 1'b1;
    wait_stb("t2");
    chk("t2_underrun", underrun, 1'b0);
    chk("t2_level_pop", fifo_level, 3'd0);
    capture(64, -1, d, lr, first);
    chk("t2_first_rise", first, 2);
    chk("t2_data", d, exp_frame(24'hA5C3F1, 24'h5A3C0F));
    chk("t2_lrclk", lr, LR_EXP);

    // Fill FIFO, overflow attempt, drain in order, then starve
    do_reset();
    for (int i = 0; i < 4; i++) write_frame(fl[i], fr[i]);
    chk("t3_ready_full", din_ready, 1'b0);
    chk("t3_level_full", fifo_level, 3'd4);
    din_valid = 1'b1; l_data_in = 24'h777777; r_data_in = 24'h333333;
    tick(); tick();
    din_valid = 1'b0;
    chk("t3_level_hold", fifo_level, 3'd4);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_stb($sformatf("t3_f%0d", i));
      chk($sformatf("t3_underrun%0d", i), underrun, 1'b0);
      chk($sformatf("t3_level%0d", i), fifo_level, 3'(3 - i));
      capture(64, -1, d, lr, first);
      chk($sformatf("t3_data%0d", i), d, exp_frame(fl[i], fr[i]));
    end
    wait_stb("t3_starve");
    chk("t3_starve_underrun", underrun, 1'b1);
    capture(64, -1, d, lr, first);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    chk("t3_starve_data", d, exp_frame(24'h000001, 24'hFFFFFF));
`else
    chk("t3_starve_data", d, 64'h0);
`endif
    chk("t3_starve_lrclk", lr, LR_EXP);

    // Simultaneous push/pop, then stop mid-frame
    do_reset();
    for (int i = 0; i < 3; i++) write_frame(fl[i], fr[i]);
    enable = 1'b1;
    wait_stb("t4");
    chk("t4_level", fifo_level, 3'd2);
    capture(64, -1, d, lr, first);
    chk("t4_data0", d, exp_frame(fl[0], fr[0]));
    tick();
    din_valid = 1'b1; l_data_in = fl[3]; r_data_in = fr[3];
    tick();
    din_valid = 1'b0;
    chk("t4_pushpop_stb", frame_stb, 1'b1);
    chk("t4_pushpop_underrun", underrun, 1'b0);
    chk("t4_pushpop_level", fifo_level, 3'd2);
    capture(64, 10, d, lr, first);
    chk("t4_data1_complete", d, exp_frame(fl[1], fr[1]));
    chk("t4_lrclk1", lr, LR_EXP);
    nstb = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (frame_stb) nstb++;
    end
    chk("t4_no_reload", nstb, 0);
    chk("t4_idle_bclk", bclk, 1'b0);
    chk("t4_idle_lrclk", lrclk, 1'b0);
    chk("t4_idle_sdata", sdata, 1'b0);
    chk("t4_idle_level", fifo_level, 3'd2);

    // Reset mid-frame at bit 40 with two frames still buffered
    write_frame(24'hA5C3F1, 24'h5A3C0F);
    chk("t5_level_pre", fifo_level, 3'd3);
    enable = 1'b1;
    wait_stb("t5");
    chk("t5_level_run", fifo_level, 3'd2);
    capture(41, -1, d, lr, first);
    chk("t5_lrclk_right", lrclk, 1'b1);
    reset = 1'b1; enable = 1'b0;
    tick();
    chk("t5_rst_bclk", bclk, 1'b0);
    chk("t5_rst_lrclk", lrclk, 1'b0);
    chk("t5_rst_sdata", sdata, 1'b0);
    chk("t5_rst_stb", frame_stb, 1'b0);
    chk("t5_rst_level", fifo_level, 3'd0);
    chk("t5_rst_ready", din_ready, 1'b1);
    reset = 1'b0;
    nstb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (frame_stb || bclk) nstb++;
    end
    chk("t5_stays_idle", nstb, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/i2s_source_tx.md
Name: i2s_source_tx

Overview:
- I2S master transmitter: buffers stereo 24-bit PCM frames and serializes them onto a Philips-format I2S bus (bclk, lrclk, sdata).
- Drives the i2s_bclk / i2s_lrclk / i2s_d inputs of the audio processing chain, the other end of the I2S-to-PCM receiver.
- Used as an on-chip stimulus source and as a loopback source for the DSP path.

Parameters:
- FIFO_DEPTH, 4, number of stereo frames buffered; power of 2, minimum 2.
- BCLK_DIV, 4, clk cycles per bclk half-period; minimum 1.
- SLOT_BITS, 32, bclk periods per channel slot; fixed frame = 2*SLOT_BITS; minimum 25.

Ports:
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high
- enable  in  1  run request
- din_valid  in  1  frame-write strobe
- din_ready  out  1  high when FIFO not full
- l_data_in  in  24  left PCM, two's complement
- r_data_in  in  24  right PCM
- bclk  out  1  I2S bit clock (registered)
- lrclk  out  1  word select: 0 = left, 1 = right (registered)
- sdata  out  1  serial data, MSB first (registered)
- frame_stb  out  1  one-clk pulse when a frame is loaded for transmission
- underrun  out  1  one-clk pulse when a frame load finds the FIFO empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently buffered

Behaviour:
- Reset:
  - bclk=0, lrclk=0, sdata=0, frame_stb=0, underrun=0.
  - FIFO flushed, fifo_level=0, din_ready=1, state=IDLE.
  - Reset mid-frame aborts the frame immediately.
- FIFO write:
  - A write happens when din_valid & din_ready.
  - A write attempted while full is ignored; no state change.
  - A write and a pop in the same clk are both honoured; level is unchanged.
  - din_ready is combinational from !full.
- States:
  - IDLE: outputs held at 0. On enable=1 go to RUN, with div_cnt=0, bit_cnt=0, and a frame load in the same clk.
  - RUN: on enable=0, finish the current frame. At the next frame boundary go to IDLE instead of loading. The FIFO is retained.
- Bit clock:
  - div_cnt counts 0..BCLK_DIV-1; bclk toggles when div_cnt wraps.
  - bclk rises BCLK_DIV clks after entering RUN.
  - All sdata/lrclk changes coincide with bclk falling edges (or RUN entry), so the receiver samples on rising edges.
- Framing:
  - bit_cnt runs 0..2*SLOT_BITS-1 and advances on each bclk falling edge.
  - lrclk = 0 for bit_cnt < SLOT_BITS, 1 otherwise.
  - One-bit I2S delay: sdata at bit_cnt 1..24 = left[23:0]; at SLOT_BITS+1..SLOT_BITS+24 = right[23:0]; all other slots = 0.
  - Loaded data comes from a 2*SLOT_BITS shift register filled at frame load.
- Frame load:
  - Occurs at RUN entry and at each falling edge where bit_cnt wraps to 0.
  - Pops one FIFO frame and pulses frame_stb.
  - If the FIFO is empty: transmit zeros for both channels, pulse underrun together with frame_stb, no pop.
- Frame rate = clk / (2 * BCLK_DIV * 2 * SLOT_BITS).
  - Defaults at 100 MHz give ~195.3 kHz.

Optional Feature:
- Macro I2S_TX_UNDERRUN_REPEAT_EN.
  - Defined: on underrun, retransmit the last successfully popped frame (zeros if none since reset).
  - Undefined: transmit zeros on underrun.
- underrun pulses in both builds.

Test Plan:
- Reset then enable=1 with empty FIFO, BCLK_DIV=2 -> bclk first rises at clk 2; first frame all zeros; underrun and frame_stb pulse together at RUN entry; lrclk low for 32 bclks then high for 32.
- Write L=0xA5C3F1, R=0x5A3C0F before enable -> the receiver sampling on bclk rising recovers L on lrclk=0 and R on lrclk=1; bits 25..31 of each slot = 0; no underrun on first frame.
- Write 4 frames with FIFO_DEPTH=4 and a 5th with din_valid held -> din_ready=0, fifo_level=4; 5th frame ignored; the 4 frames transmitted in order.
- Drop enable at bit_cnt=10 -> frame completes all 64 bclks, then bclk/lrclk/sdata=0; remaining frames stay in FIFO (fifo_level unchanged).
- Assert reset at bit_cnt=40 with 2 frames buffered -> next clk all outputs 0, fifo_level=0, state IDLE.
- With macro defined, transmit L=0x000001, R=0xFFFFFF then starve -> next frame repeats 0x000001/0xFFFFFF with underrun pulse; without macro -> zeros.
